// File: rtl/control_pkg.sv
// Shared definitions for the Lab B sequencing controller: opcodes, state
// encodings, ALU select codes and the opcode-to-execute-state mapping.
package control_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOADA  = 4'd4,
    ST_LOADB  = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Unassigned opcodes fall through to Noop.
  function automatic state_e exec_state(input logic [3:0] op);
    case (op)
      OP_STORE: exec_state = ST_STORE;
      OP_LOAD:  exec_state = ST_LOADA;
      OP_ADD:   exec_state = ST_ADD;
      OP_SUB:   exec_state = ST_SUB;
      OP_HALT:  exec_state = ST_HALT;
      default:  exec_state = ST_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Purely combinational field extraction and Moore output decode from the
// current state and instruction register.
module ir_decode
  import control_pkg::*;
(
  input  state_e      state,
  input  logic [15:0] ir,
  output state_e      next_exec,
  output logic        pc_clr,
  output logic        pc_up,
  output logic [7:0]  d_addr,
  output logic        d_wr,
  output logic        rf_s,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_wr,
  output logic [3:0]  rf_ra_addr,
  output logic        rf_ra_rd,
  output logic [3:0]  rf_rb_addr,
  output logic        rf_rb_rd,
  output logic [2:0]  alu_s0
);

  assign next_exec = exec_state(ir[15:12]);

  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    d_addr     = 8'd0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'd0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = 4'd0;
    rf_ra_rd   = 1'b0;
    rf_rb_addr = 4'd0;
    rf_rb_rd   = 1'b0;
    alu_s0     = ALU_PASS;

    case (state)
      ST_INIT:  pc_clr = 1'b1;
      ST_FETCH: pc_up  = 1'b1;
      ST_LOADA, ST_LOADB: begin
        d_addr    = ir[11:4];
        rf_s      = 1'b1;
        rf_w_addr = ir[3:0];
        // Write only in the second cycle, once memory read data has settled.
        rf_w_wr   = (state == ST_LOADB);
      end
      ST_STORE: begin
        d_addr     = ir[7:0];
        rf_ra_addr = ir[11:8];
        rf_ra_rd   = 1'b1;
        d_wr       = 1'b1;
        alu_s0     = ALU_PASS;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr = ir[11:8];
        rf_rb_addr = ir[7:4];
        rf_ra_rd   = 1'b1;
        rf_rb_rd   = 1'b1;
        rf_w_addr  = ir[3:0];
        rf_w_wr    = 1'b1;
        rf_s       = 1'b0;
        alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the Lab B processor; owns the state
// register and instruction register, output decode lives in ir_decode.
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] Instr,
  output logic        PC_clr,
  output logic        PC_up,
  output logic [15:0] IR_out,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_wr,
  output logic [3:0]  RF_Ra_addr,
  output logic        RF_Ra_rd,
  output logic [3:0]  RF_Rb_addr,
  output logic        RF_Rb_rd,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State
);

  state_e      state_q, state_d;
  state_e      next_exec;
  logic [15:0] ir_q, ir_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_INIT;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR captures the ROM word on the edge leaving Fetch, the same edge the PC advances.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_DECODE;
        ir_d    = Instr;
      end
      ST_DECODE: state_d = next_exec;
      ST_LOADA:  state_d = ST_LOADB;
      ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  ir_decode u_ir_decode (
    .state      (state_q),
    .ir         (ir_q),
    .next_exec  (next_exec),
    .pc_clr     (PC_clr),
    .pc_up      (PC_up),
    .d_addr     (D_addr),
    .d_wr       (D_wr),
    .rf_s       (RF_s),
    .rf_w_addr  (RF_W_addr),
    .rf_w_wr    (RF_W_wr),
    .rf_ra_addr (RF_Ra_addr),
    .rf_ra_rd   (RF_Ra_rd),
    .rf_rb_addr (RF_Rb_addr),
    .rf_rb_rd   (RF_Rb_rd),
    .alu_s0     (ALU_s0)
  );

  assign State  = state_q;
  assign IR_out = ir_q;

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the Lab B single-cycle-per-state processor. It owns the instruction register and the fetch/decode/execute state machine. It drives the program counter's clear and increment controls and issues the strobes for data memory, register file and ALU. It sits between the 32-word instruction ROM (addressed by the PC) and the datapath.

## Interface
- No parameters; the 5-bit PC and 16-bit instruction widths are fixed.
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Instr  input  16  ROM word at current PC; valid combinationally.
- PC_clr  output  1  PC clear request.
- PC_up  output  1  PC increment request.
- IR_out  output  16  current instruction register contents.
- D_addr  output  8  data memory address.
- D_wr  output  1  data memory write strobe.
- RF_s  output  1  register-file write-data select: 1 = data memory, 0 = ALU.
- RF_W_addr  output  4  register-file write address.
- RF_W_wr  output  1  register-file write strobe.
- RF_Ra_addr  output  4  register-file read port A address.
- RF_Ra_rd  output  1  read enable for port A.
- RF_Rb_addr  output  4  register-file read port B address.
- RF_Rb_rd  output  1  read enable for port B.
- ALU_s0  output  3  ALU function: 0 = pass A, 1 = A+B, 2 = A−B.
- State  output  4  current state encoding, for debug and bench.

## Operation
- Instruction formats:
  - NOOP: op 0000.
  - STORE: op 0001, [11:8] Ra, [7:0] addr.
  - LOAD: op 0010, [11:4] addr, [3:0] Rd.
  - ADD: op 0011, [11:8] Ra, [7:4] Rb, [3:0] Rd.
  - SUB: op 0100, same fields as ADD.
  - HALT: op 0101.
  - Opcodes 0110–1111 execute as NOOP.
- States: Init, Fetch, Decode, Noop, LoadA, LoadB, Store, Add, Sub, Halt.
- Transitions:
  - Init → Fetch.
  - Fetch → Decode.
  - Decode → state selected by IR[15:12].
  - LoadA → LoadB.
  - Noop, LoadB, Store, Add and Sub → Fetch.
  - Halt → Halt, until reset.
- Outputs are Moore decodes of state and IR. Every strobe not listed for a state is 0, and unused addresses hold 0.
  - Init: PC_clr = 1.
  - Fetch: PC_up = 1. IR loads Instr on the exiting edge; the PC advances on the same edge, so the IR holds the word at the pre-increment PC.
  - Decode: no strobes.
  - LoadA: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0].
  - LoadB: the LoadA values plus RF_W_wr = 1. The extra cycle covers memory read latency.
  - Store: D_addr = IR[7:0], RF_Ra_addr = IR[11:8], RF_Ra_rd = 1, D_wr = 1. ALU_s0 = 0 so the ALU passes A to memory.
  - Add/Sub: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], both read enables set, RF_W_addr = IR[3:0], RF_W_wr = 1, RF_s = 0, ALU_s0 = 1 (Add) or 2 (Sub).
  - Halt: all strobes 0. PC frozen.
- Reset (Resetn = 0, any cycle): state → Init and IR → 0 immediately.
  - Outputs then read PC_clr = 1 and all else 0.
  - An instruction in flight is abandoned with no write strobe.

## Timing
- Cycles from Fetch entry to next Fetch entry: NOOP 3, STORE 3, ADD/SUB 3, LOAD 4.
- First Fetch occurs one rising edge after Resetn deasserts.
  - The PC is cleared on that edge, because PC_clr is high in Init.
- PC_clr and PC_up are never both 1.
- At most one of D_wr and RF_W_wr is 1 in any cycle.
- PC wrap (31 → 0) is the PC's concern; the controller keeps fetching.
- Resetn deassertion is assumed synchronous to Clock upstream. The block adds no synchronizer.

## Structure
- Shared package control_pkg holds:
  - opcode constants
  - state encodings (4-bit binary, Init = 0)
  - ALU select codes
- One sub-module, ir_decode: purely combinational field extraction and output decode from state and IR.
- The state register and IR live in control_unit.

## Test plan
- Reset: hold Resetn = 0 mid-Add with RF_W_wr high → same cycle State = Init, RF_W_wr = 0, PC_clr = 1, IR_out = 0. Release → Fetch after one edge.
- LOAD 16'h2A53: Fetch, Decode, then LoadA with D_addr = 8'hA5, RF_W_addr = 3, RF_s = 1. Then LoadB with RF_W_wr = 1 for exactly one cycle.
- STORE 16'h1742: Store state gives D_addr = 8'h42, RF_Ra_addr = 7, D_wr = 1 for one cycle, ALU_s0 = 0.
- ADD 16'h3129 then SUB 16'h4129: write to R9 from R1 and R2, ALU_s0 = 1 then 2. Fetch entries are 3 cycles apart; PC_up pulses once per instruction.
- Undefined opcode 16'hF000 → behaves as NOOP, with no strobes in the execute cycle.
- HALT 16'h5000: State stays Halt for 20 cycles with PC_up = 0. Resetn pulse → Init → Fetch from PC 0.
